// File: rtl/cp0_pkg.sv
// cp0_pkg: shared constants for the coprocessor-0 exception controller.
//   - CP0 register indices reachable by mfc0/mtc0
//   - Cause.ExcCode encodings
//   - next-PC select encodings driven on Selpc
//   - state type of the interrupt-acknowledge machine
package cp0_pkg;

  localparam logic [4:0] C0_STATUS = 5'd12;
  localparam logic [4:0] C0_CAUSE  = 5'd13;
  localparam logic [4:0] C0_EPC    = 5'd14;

  localparam logic [1:0] EXC_INT    = 2'b00;
  localparam logic [1:0] EXC_SYS    = 2'b01;
  localparam logic [1:0] EXC_UNIMPL = 2'b10;
  localparam logic [1:0] EXC_OVR    = 2'b11;

  localparam logic [1:0] SEL_SEQ = 2'b00;
  localparam logic [1:0] SEL_EPC = 2'b10;
  localparam logic [1:0] SEL_VEC = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } ack_state_e;

endpackage

// File: rtl/intr_sync.sv
// intr_sync: brings the asynchronous interrupt level into the clk domain and
// flags its rising edge for one cycle.
// Ports:
//   clk       in  clock, rising edge
//   rst       in  asynchronous active-high reset (clears chain and edge history)
//   async_in  in  asynchronous level input
//   rise      out one-cycle pulse when the synchronised level goes 0 -> 1
module intr_sync
  import cp0_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   last_q;
  logic                   last_d;

  // Stage 0 samples the raw input; every later stage samples its predecessor.
  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_chain
      if (gi == 0) begin : g_first
        assign sync_d[gi] = async_in;
      end else begin : g_rest
        assign sync_d[gi] = sync_q[gi-1];
      end
    end
  endgenerate

  assign last_d = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      last_q <= last_d;
    end
  end

  // Edge is taken on the last synchronised stage only, never on a metastable one.
  assign rise = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: coprocessor-0 exception/interrupt controller.
// Holds Status/Cause/EPC, arbitrates exceptions against the synchronised
// external interrupt, serves mfc0/mtc0/eret and steers the next-PC mux.
// Ports:
//   Clk, Rst            clock (rising edge), asynchronous active-high reset
//   Intr                asynchronous level interrupt request
//   Ovr/Unimpl/Syscall  exception causes raised by the current instruction
//   Eret                current instruction is eret
//   Instr_ok            current instruction commits (interrupt boundary)
//   Mtc0/C0_addr/Wdata  CP0 register write port
//   Pc/Pc_plus4         current and sequential PC
//   Rdata               mfc0 read data (combinational on C0_addr)
//   Selpc               next-PC select: 00 seq, 10 EPC, 11 vector
//   Epc/Vector          PC-mux operands
//   Cancel              suppress writes of the current instruction
//   Inta                one-cycle interrupt acknowledge
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] VEC_ADDR    = 32'h0000_0008,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Intr,
  input  logic        Ovr,
  input  logic        Unimpl,
  input  logic        Syscall,
  input  logic        Eret,
  input  logic        Instr_ok,
  input  logic        Mtc0,
  input  logic [4:0]  C0_addr,
  input  logic [31:0] Wdata,
  input  logic [31:0] Pc,
  input  logic [31:0] Pc_plus4,
  output logic [31:0] Rdata,
  output logic [1:0]  Selpc,
  output logic [31:0] Epc,
  output logic [31:0] Vector,
  output logic        Cancel,
  output logic        Inta
);

  // Only implemented bits are stored: Status[11:0] and Cause.ExcCode.
  logic [11:0] status_q, status_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic        pend_q, pend_d;
  ack_state_e  state_q, state_d;

  logic        intr_rise;
  logic        take_exc;
  logic        take_intr;
  logic        take_eret;
  logic [1:0]  exc_code;

  intr_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_intr_sync (
    .clk      (Clk),
    .rst      (Rst),
    .async_in (Intr),
    .rise     (intr_rise)
  );

  // Priority decode. A masked cause is treated as absent, so it neither
  // redirects the PC nor blocks a lower-priority enabled cause.
  always_comb begin
    take_exc  = 1'b0;
    take_intr = 1'b0;
    exc_code  = EXC_INT;
    if (Ovr && status_q[3]) begin
      take_exc = 1'b1;
      exc_code = EXC_OVR;
    end else if (Unimpl && status_q[2]) begin
      take_exc = 1'b1;
      exc_code = EXC_UNIMPL;
    end else if (Syscall && status_q[1]) begin
      take_exc = 1'b1;
      exc_code = EXC_SYS;
    end else if (pend_q && Instr_ok && status_q[0]) begin
      take_intr = 1'b1;
    end
    take_eret = Eret & ~take_exc & ~take_intr;
  end

  always_comb begin
    Selpc = SEL_SEQ;
    if (take_exc || take_intr) begin
      Selpc = SEL_VEC;
    end else if (take_eret) begin
      Selpc = SEL_EPC;
    end
  end

  // Interrupts let the instruction commit; only exceptions cancel it.
  assign Cancel = take_exc;
  assign Inta   = (state_q == ST_ACK);
  assign Epc    = epc_q;
  assign Vector = VEC_ADDR;

  always_comb begin
    Rdata = 32'h0;
    case (C0_addr)
      C0_STATUS: Rdata = {20'h0, status_q};
      C0_CAUSE:  Rdata = {28'h0, cause_q, 2'b00};
      C0_EPC:    Rdata = epc_q;
      default:   Rdata = 32'h0;
    endcase
  end

  // Register next-state. Entry pushes the 4-bit mask group up the 3-deep
  // stack with zeroed masks; eret pops it. An mtc0 in a trapping cycle is
  // dropped; alongside eret it is applied after the pop and wins.
  always_comb begin
    status_d = status_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    if (take_exc || take_intr) begin
      epc_d    = take_exc ? Pc : Pc_plus4;
      cause_d  = exc_code;
      status_d = {status_q[7:0], 4'b0000};
    end else begin
      if (take_eret) begin
        status_d = {4'b0000, status_q[11:4]};
      end
      if (Mtc0) begin
        case (C0_addr)
          C0_STATUS: status_d = Wdata[11:0];
          C0_EPC:    epc_d    = Wdata;
          default:   ;
        endcase
      end
    end
  end

  // A new edge arriving while the old request is consumed re-arms pend.
  always_comb begin
    pend_d = (pend_q & ~take_intr) | intr_rise;
  end

  // ACK lasts exactly one cycle, whatever happens next.
  always_comb begin
    state_d = ST_IDLE;
    if (state_q == ST_IDLE && take_intr) begin
      state_d = ST_ACK;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      status_q <= '0;
      cause_q  <= '0;
      epc_q    <= '0;
      pend_q   <= 1'b0;
      state_q  <= ST_IDLE;
    end else begin
      status_q <= status_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
      pend_q   <= pend_d;
      state_q  <= state_d;
    end
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb_cp0_exc_ctrl: directed scoreboard bench for cp0_exc_ctrl.
// Stimulus pushes hand-computed expectations tagged with the cycle they
// belong to; a monitor pops and compares them at the falling edge (or on
// demand for the asynchronous reset check).
module tb_cp0_exc_ctrl;

  localparam int SIG_SELPC  = 0;
  localparam int SIG_CANCEL = 1;
  localparam int SIG_EPC    = 2;
  localparam int SIG_RDATA  = 3;
  localparam int SIG_INTA   = 4;
  localparam int SIG_VECTOR = 5;

  typedef struct {
    string       name;
    int          sig;
    logic [31:0] exp;
    int          cyc;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Intr = 1'b0, Ovr = 1'b0, Unimpl = 1'b0, Syscall = 1'b0;
  logic        Eret = 1'b0, Instr_ok = 1'b0, Mtc0 = 1'b0;
  logic [4:0]  C0_addr = 5'd0;
  logic [31:0] Wdata = 32'h0, Pc = 32'h0, Pc_plus4 = 32'h0;
  logic [31:0] Rdata, Epc, Vector;
  logic [1:0]  Selpc;
  logic        Cancel, Inta;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc_cnt  = 0;
  event chk_ev;

  cp0_exc_ctrl #(
    .VEC_ADDR    (32'h0000_0008),
    .SYNC_STAGES (2)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Intr     (Intr),
    .Ovr      (Ovr),
    .Unimpl   (Unimpl),
    .Syscall  (Syscall),
    .Eret     (Eret),
    .Instr_ok (Instr_ok),
    .Mtc0     (Mtc0),
    .C0_addr  (C0_addr),
    .Wdata    (Wdata),
    .Pc       (Pc),
    .Pc_plus4 (Pc_plus4),
    .Rdata    (Rdata),
    .Selpc    (Selpc),
    .Epc      (Epc),
    .Vector   (Vector),
    .Cancel   (Cancel),
    .Inta     (Inta)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [31:0] actual(int sig);
    case (sig)
      SIG_SELPC:  return {30'h0, Selpc};
      SIG_CANCEL: return {31'h0, Cancel};
      SIG_EPC:    return Epc;
      SIG_RDATA:  return Rdata;
      SIG_INTA:   return {31'h0, Inta};
      default:    return Vector;
    endcase
  endfunction

  // Monitor: consume every expectation due in the current cycle.
  initial begin
    forever begin
      @(negedge Clk or chk_ev);
      while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
        exp_t e;
        logic [31:0] a;
        e = q.pop_front();
        a = actual(e.sig);
        n_checks++;
        if (e.cyc != cyc_cnt) begin
          $display("FAIL %s: check missed its cycle %0d (now %0d)", e.name, e.cyc, cyc_cnt);
        end else if (a !== e.exp) begin
          $display("FAIL %s: got 32'h%08h, expected 32'h%08h", e.name, a, e.exp);
        end else begin
          n_pass++;
        end
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic expect_val(string name, int sig, logic [31:0] v);
    exp_t e;
    e.name = name;
    e.sig  = sig;
    e.exp  = v;
    e.cyc  = cyc_cnt;
    q.push_back(e);
    $display("[cyc %0d] expect %s = 32'h%08h", cyc_cnt, name, v);
  endtask

  task automatic write_c0(logic [4:0] addr, logic [31:0] d);
    Mtc0 = 1'b1; C0_addr = addr; Wdata = d;
    step();
    Mtc0 = 1'b0;
  endtask

  initial begin
    // Reset state
    step(); step();
    Rst = 1'b0;
    C0_addr = 5'd12;
    expect_val("rst_status", SIG_RDATA, 32'h0);
    expect_val("rst_selpc", SIG_SELPC, 32'h0);
    expect_val("rst_cancel", SIG_CANCEL, 32'h0);
    expect_val("rst_inta", SIG_INTA, 32'h0);
    expect_val("rst_epc", SIG_EPC, 32'h0);
    expect_val("vector", SIG_VECTOR, 32'h8);
    step();
    C0_addr = 5'd13;
    expect_val("rst_cause", SIG_RDATA, 32'h0);

    // Status write; unimplemented upper bits read back as 0
    step();
    write_c0(5'd12, 32'hFFF0_000F);
    C0_addr = 5'd12;
    expect_val("status_wr", SIG_RDATA, 32'h0000_000F);

    // Overflow taken; concurrent mtc0 EPC is dropped
    step();
    Pc = 32'h100; Ovr = 1'b1;
    Mtc0 = 1'b1; C0_addr = 5'd14; Wdata = 32'hDEAD;
    expect_val("ovr_selpc", SIG_SELPC, 32'h3);
    expect_val("ovr_cancel", SIG_CANCEL, 32'h1);
    step();
    Ovr = 1'b0; Mtc0 = 1'b0; C0_addr = 5'd14;
    expect_val("ovr_epc_rd", SIG_RDATA, 32'h100);
    expect_val("ovr_epc", SIG_EPC, 32'h100);
    expect_val("ovr_after_selpc", SIG_SELPC, 32'h0);
    step();
    C0_addr = 5'd13;
    expect_val("ovr_cause", SIG_RDATA, 32'hC);
    step();
    C0_addr = 5'd12;
    expect_val("ovr_status", SIG_RDATA, 32'hF0);

    // Eret restores masks
    step();
    Eret = 1'b1;
    expect_val("eret_selpc", SIG_SELPC, 32'h2);
    expect_val("eret_cancel", SIG_CANCEL, 32'h0);
    step();
    Eret = 1'b0;
    expect_val("eret_status", SIG_RDATA, 32'h0F);
    step();
    C0_addr = 5'd14;
    expect_val("eret_epc_rd", SIG_RDATA, 32'h100);

    // Masked syscall has no effect; mtc0 to Cause is ignored
    step();
    write_c0(5'd12, 32'h0);
    Syscall = 1'b1; Pc = 32'h180;
    expect_val("msk_sys_selpc", SIG_SELPC, 32'h0);
    expect_val("msk_sys_cancel", SIG_CANCEL, 32'h0);
    step();
    Syscall = 1'b0;
    write_c0(5'd13, 32'h0000_0004);
    C0_addr = 5'd13;
    expect_val("cause_ro", SIG_RDATA, 32'hC);
    expect_val("msk_sys_epc", SIG_EPC, 32'h100);

    // Interrupt: one-cycle pulse, taken after the synchroniser delay
    step();
    write_c0(5'd12, 32'h1);
    Instr_ok = 1'b1; Pc = 32'h200; Pc_plus4 = 32'h204; Intr = 1'b1;
    expect_val("int_c0_selpc", SIG_SELPC, 32'h0);
    step();
    Intr = 1'b0;
    expect_val("int_c1_selpc", SIG_SELPC, 32'h0);
    step();
    expect_val("int_c2_selpc", SIG_SELPC, 32'h0);
    step();
    expect_val("int_take_selpc", SIG_SELPC, 32'h3);
    expect_val("int_take_cancel", SIG_CANCEL, 32'h0);
    expect_val("int_take_inta", SIG_INTA, 32'h0);
    step();
    expect_val("int_ack_inta", SIG_INTA, 32'h1);
    expect_val("int_epc", SIG_EPC, 32'h204);
    expect_val("int_ack_selpc", SIG_SELPC, 32'h0);
    step();
    C0_addr = 5'd13;
    expect_val("int_post_inta", SIG_INTA, 32'h0);
    expect_val("int_cause", SIG_RDATA, 32'h0);
    step();
    C0_addr = 5'd12;
    expect_val("int_status", SIG_RDATA, 32'h10);

    // Pending interrupt loses to unimpl, survives, and is taken after eret
    step();
    write_c0(5'd12, 32'hF);
    Instr_ok = 1'b0; Intr = 1'b1;
    step();
    Intr = 1'b0;
    step();
    step();
    Unimpl = 1'b1; Instr_ok = 1'b1; Pc = 32'h300; Pc_plus4 = 32'h304;
    expect_val("unimpl_selpc", SIG_SELPC, 32'h3);
    expect_val("unimpl_cancel", SIG_CANCEL, 32'h1);
    step();
    Unimpl = 1'b0; Instr_ok = 1'b0; C0_addr = 5'd13;
    expect_val("unimpl_cause", SIG_RDATA, 32'h8);
    expect_val("unimpl_epc", SIG_EPC, 32'h300);
    expect_val("unimpl_inta", SIG_INTA, 32'h0);
    step();
    Eret = 1'b1;
    expect_val("eret2_selpc", SIG_SELPC, 32'h2);
    step();
    Eret = 1'b0; Instr_ok = 1'b1; Pc_plus4 = 32'h404;
    expect_val("pend_take_selpc", SIG_SELPC, 32'h3);
    expect_val("pend_take_cancel", SIG_CANCEL, 32'h0);
    step();
    Instr_ok = 1'b0; C0_addr = 5'd12;
    expect_val("pend_ack_inta", SIG_INTA, 32'h1);
    expect_val("pend_epc", SIG_EPC, 32'h404);

    // Asynchronous reset in the ACK cycle, checked before any clock edge
    @(negedge Clk);
    #1;
    Rst = 1'b1;
    #1;
    expect_val("arst_inta", SIG_INTA, 32'h0);
    expect_val("arst_epc", SIG_EPC, 32'h0);
    expect_val("arst_status", SIG_RDATA, 32'h0);
    expect_val("arst_selpc", SIG_SELPC, 32'h0);
    -> chk_ev;
    #1;

    // Pending request was discarded by reset
    step();
    Rst = 1'b0;
    write_c0(5'd12, 32'h1);
    Instr_ok = 1'b1;
    expect_val("arst_nopend_selpc", SIG_SELPC, 32'h0);
    step();
    C0_addr = 5'd13;
    expect_val("arst_cause", SIG_RDATA, 32'h0);

    @(negedge Clk);
    #1;
    if (q.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", q.size());
      n_checks += q.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
